// File: rtl/switch_nport_pkg.sv
// Shared constants and helpers for the N-port packet switch.
// Holds default parameters, the round-robin picker and a mask popcount.
package switch_nport_pkg;

  localparam int unsigned DEF_NUM_PORTS     = 4;
  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_FIFO_DEPTH    = 4;
  localparam int unsigned DEF_ALLOW_HAIRPIN = 0;

  localparam int unsigned MAX_PORTS = 8;
  localparam int unsigned PTR_W     = 3;
  localparam int unsigned CNT_W     = 4;

  // One-hot grant for the first requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input logic [PTR_W-1:0]     ptr,
                                                   input int unsigned          n);
    logic [MAX_PORTS-1:0] gnt;
    logic                 found;
    logic [PTR_W-1:0]     idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < MAX_PORTS; off++) begin
      idx = PTR_W'((32'(ptr) + off) % n);
      if ((off < n) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_PORTS-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < MAX_PORTS; b++) begin
      c = c + CNT_W'(m[b]);
    end
    return c;
  endfunction

endpackage

// File: rtl/switch_port_fifo.sv
// Ingress FIFO: registered full/empty flags, combinational head read.
// DEPTH must be a power of two so the pointers wrap naturally.
module switch_port_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] head_c,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: the flags and pointers gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/switch_nport.sv
// N-port packet switch: per-ingress FIFOs, per-egress round-robin arbiters,
// multicast serialised per egress via served masks, saturating drop counter.
module switch_nport
  import switch_nport_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = DEF_NUM_PORTS,
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
  parameter int unsigned ALLOW_HAIRPIN = DEF_ALLOW_HAIRPIN
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                in_valid,
  output logic [NUM_PORTS-1:0]                in_ready,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_source,
  input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] in_target,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    in_data,
  output logic [NUM_PORTS-1:0]                out_valid,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_source,
  output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_target,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]    out_data,
  output logic [15:0]                         drop_count
);

  // FIFO entry layout, MSB first: {source, original target, effective mask, data}.
  localparam int unsigned ENT_W   = 3 * NUM_PORTS + DATA_W;
  localparam int unsigned EFF_LSB = DATA_W;
  localparam int unsigned TGT_LSB = DATA_W + NUM_PORTS;
  localparam int unsigned SRC_LSB = DATA_W + 2 * NUM_PORTS;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] eff_c;
  logic [NUM_PORTS-1:0]                accept, push, drop, pop;
  logic [NUM_PORTS-1:0][ENT_W-1:0]     wdata, head;
  logic [NUM_PORTS-1:0]                fifo_full, fifo_empty;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] h_src, h_tgt, h_eff, rem;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    h_data;
  logic [NUM_PORTS-1:0][MAX_PORTS-1:0] req_col, pick;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_eg;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] gnt_in;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] served_q, served_d;
  logic [NUM_PORTS-1:0][PTR_W-1:0]     ptr_q, ptr_d;

  logic [NUM_PORTS-1:0]                out_valid_q, out_valid_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_source_q, out_source_d;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] out_target_q, out_target_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    out_data_q, out_data_d;

  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

  assign in_ready = ~fifo_full;

  // Ingress: effective mask, accept/drop decision and FIFO write word.
  always_comb begin
    eff_c  = in_target;
    accept = '0;
    push   = '0;
    drop   = '0;
    wdata  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ALLOW_HAIRPIN == 0) eff_c[i][i] = 1'b0;
      accept[i] = in_valid[i] & in_ready[i];
      push[i]   = accept[i] & (|eff_c[i]);
      drop[i]   = accept[i] & ~(|eff_c[i]);
      wdata[i]  = {in_source[i], in_target[i], eff_c[i], in_data[i]};
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_fifo
    switch_port_fifo #(
      .W     (ENT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[gi]),
      .pop_i   (pop[gi]),
      .wdata_i (wdata[gi]),
      .head_c  (head[gi]),
      .full_o  (fifo_full[gi]),
      .empty_o (fifo_empty[gi])
    );
  end

  // Requests, per-egress round-robin grants, head pop and served-mask update.
  always_comb begin
    h_src    = '0;
    h_tgt    = '0;
    h_eff    = '0;
    h_data   = '0;
    rem      = '0;
    req_col  = '0;
    pick     = '0;
    gnt_eg   = '0;
    gnt_in   = '0;
    pop      = '0;
    served_d = served_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      h_src[i]  = head[i][SRC_LSB +: NUM_PORTS];
      h_tgt[i]  = head[i][TGT_LSB +: NUM_PORTS];
      h_eff[i]  = head[i][EFF_LSB +: NUM_PORTS];
      h_data[i] = head[i][DATA_W-1:0];
      rem[i]    = fifo_empty[i] ? '0 : (h_eff[i] & ~served_q[i]);
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        req_col[o][i] = rem[i][o];
      end
      pick[o]   = rr_pick(req_col[o], ptr_q[o], NUM_PORTS);
      gnt_eg[o] = pick[o][NUM_PORTS-1:0];
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        gnt_in[i][o] = gnt_eg[o][i];
      end
      pop[i]      = ~fifo_empty[i] & ((rem[i] & ~gnt_in[i]) == '0);
      served_d[i] = pop[i] ? '0 : (served_q[i] | gnt_in[i]);
    end
  end

  // Pointer advance and output capture of the granted head.
  always_comb begin
    ptr_d        = ptr_q;
    out_valid_d  = '0;
    out_source_d = '0;
    out_target_d = '0;
    out_data_d   = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (gnt_eg[o][i]) begin
          ptr_d[o]        = PTR_W'((i + 1) % NUM_PORTS);
          out_valid_d[o]  = 1'b1;
          out_source_d[o] = h_src[i];
          out_target_d[o] = h_tgt[i];
          out_data_d[o]   = h_data[i];
        end
      end
    end
  end

  // Several ports may drop in the same cycle; count them all, then saturate.
  always_comb begin
    drop_sum = 17'(drop_q) + 17'(popcount(MAX_PORTS'(drop)));
    drop_d   = (drop_sum > 17'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_q     <= '0;
      ptr_q        <= '0;
      out_valid_q  <= '0;
      out_source_q <= '0;
      out_target_q <= '0;
      out_data_q   <= '0;
      drop_q       <= '0;
    end else begin
      served_q     <= served_d;
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_source_q <= out_source_d;
      out_target_q <= out_target_d;
      out_data_q   <= out_data_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_source = out_source_q;
  assign out_target = out_target_q;
  assign out_data   = out_data_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_switch_nport.sv
// Bench for switch_nport: directed scenarios plus random traffic, all checked
// against a queue-based packet model of the switch.
module tb_switch_nport;

  localparam int unsigned NP      = 4;
  localparam int unsigned DW      = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HAIRPIN = 0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NP-1:0]        in_valid;
  logic [NP-1:0]        in_ready;
  logic [NP-1:0][NP-1:0] in_source;
  logic [NP-1:0][NP-1:0] in_target;
  logic [NP-1:0][DW-1:0] in_data;
  logic [NP-1:0]        out_valid;
  logic [NP-1:0][NP-1:0] out_source;
  logic [NP-1:0][NP-1:0] out_target;
  logic [NP-1:0][DW-1:0] out_data;
  logic [15:0]          drop_count;

  switch_nport #(
    .NUM_PORTS     (NP),
    .DATA_W        (DW),
    .FIFO_DEPTH    (DEPTH),
    .ALLOW_HAIRPIN (HAIRPIN)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_source  (in_source),
    .in_target  (in_target),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_source (out_source),
    .out_target (out_target),
    .out_data   (out_data),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0] src;
    logic [NP-1:0] tgt;
    logic [NP-1:0] eff;
    logic [DW-1:0] data;
  } pkt_t;

  pkt_t            mq [NP][$];
  logic [NP-1:0]   m_served [NP];
  int              m_ptr [NP];
  int              m_drop;
  logic [2*NP+DW:0] exp_out [NP];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      m_served[i] = '0;
      m_ptr[i]    = 0;
      exp_out[i]  = '0;
    end
    m_drop = 0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    logic [NP-1:0] gmask [NP];
    bit            rdy [NP];
    logic [NP-1:0] eff;
    int            idx;
    bit            found;
    for (int i = 0; i < NP; i++) begin
      rdy[i]   = (mq[i].size() < DEPTH);
      gmask[i] = '0;
    end
    for (int o = 0; o < NP; o++) begin
      exp_out[o] = '0;
      found      = 1'b0;
      for (int k = 0; k < NP; k++) begin
        idx = (m_ptr[o] + k) % NP;
        if (!found && mq[idx].size() > 0) begin
          if (mq[idx][0].eff[o] && !m_served[idx][o]) begin
            found         = 1'b1;
            gmask[idx][o] = 1'b1;
            exp_out[o]    = {1'b1, mq[idx][0].src, mq[idx][0].tgt, mq[idx][0].data};
          end
        end
      end
      if (found) begin
        for (int i = 0; i < NP; i++) if (gmask[i][o]) m_ptr[o] = (i + 1) % NP;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (mq[i].size() > 0) begin
        m_served[i] = m_served[i] | gmask[i];
        if ((mq[i][0].eff & ~m_served[i]) == '0) begin
          void'(mq[i].pop_front());
          m_served[i] = '0;
        end
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (in_valid[i] && rdy[i]) begin
        eff = in_target[i];
        if (HAIRPIN == 0) eff[i] = 1'b0;
        if (eff == '0) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          mq[i].push_back({in_source[i], in_target[i], eff, in_data[i]});
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int o = 0; o < NP; o++) begin
      check($sformatf("out%0d", o),
            64'({out_valid[o], out_source[o], out_target[o], out_data[o]}),
            64'(exp_out[o]));
    end
    for (int i = 0; i < NP; i++) begin
      check($sformatf("in_ready%0d", i), 64'(in_ready[i]), 64'(mq[i].size() < DEPTH));
    end
    check("drop_count", 64'(drop_count), 64'(m_drop));
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    in_valid  = '0;
    in_source = '0;
    in_target = '0;
    in_data   = '0;
  endtask

  task automatic send(input int p, input logic [NP-1:0] src, input logic [NP-1:0] tgt,
                      input logic [DW-1:0] d);
    in_valid[p]  = 1'b1;
    in_source[p] = src;
    in_target[p] = tgt;
    in_data[p]   = d;
  endtask

  task automatic run_idle(input int n);
    idle();
    for (int c = 0; c < n; c++) step();
  endtask

  // Asynchronous reset asserted away from any edge; outputs must clear at once.
  task automatic mid_reset();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Unicast port0 -> egress1.
    send(0, 4'b0001, 4'b0010, 8'h51);
    step();
    run_idle(3);

    // Two-way contention on egress2, repeated.
    for (int r = 0; r < 2; r++) begin
      send(0, 4'b0001, 4'b0100, 8'hC0);
      send(1, 4'b0010, 4'b0100, 8'hC1);
      step();
      run_idle(3);
    end

    // Broadcast from port1 without hairpin.
    send(1, 4'b0010, 4'b1111, 8'hB2);
    step();
    run_idle(3);

    // Multicast serialisation against a unicast on egress2.
    send(0, 4'b0001, 4'b1110, 8'hA1);
    send(3, 4'b1000, 4'b0100, 8'hE3);
    step();
    run_idle(4);

    // Backpressure: ports 0 and 2 both stream into egress1.
    for (int c = 0; c < 10; c++) begin
      idle();
      send(0, 4'b0001, 4'b0010, DW'(8'h10 + c));
      send(2, 4'b0100, 4'b0010, DW'(8'h20 + c));
      step();
    end
    run_idle(12);

    // Self-only target is dropped.
    send(2, 4'b0100, 4'b0100, 8'h77);
    step();
    run_idle(2);

    // Reset with packets queued at port0.
    for (int c = 0; c < 4; c++) begin
      idle();
      send(0, 4'b0001, 4'b1000, DW'(8'h30 + c));
      send(1, 4'b0010, 4'b1000, DW'(8'h40 + c));
      send(2, 4'b0100, 4'b1000, DW'(8'h50 + c));
      step();
    end
    mid_reset();
    run_idle(6);

    // Random traffic with one reset in the middle.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NP; i++) begin
        in_valid[i]  = ($urandom_range(0, 99) < 55);
        in_source[i] = NP'($urandom);
        in_target[i] = NP'($urandom);
        in_data[i]   = DW'($urandom);
      end
      step();
      if (c == 300) begin
        mid_reset();
      end
    end
    run_idle(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_nport.md
Name: switch_nport

Overview:
- Parametrised N-port packet switch; next generation of the 4-port switch, sitting at the same level of the design.
- Each ingress port has a FIFO with ready/valid backpressure.
- Each egress port has a round-robin arbiter.
- Multicast packets are delivered to all targets, serialised per egress port; optional hairpin (self-delivery) mode; saturating drop counter.

Parameters:
- NUM_PORTS, 4, number of ports (2..8); source/target masks are NUM_PORTS bits, one bit per port.
- DATA_W, 8, payload width.
- FIFO_DEPTH, 4, entries per ingress FIFO (power of 2, ≥2).
- ALLOW_HAIRPIN, 0, 1 = a packet may be delivered back to its own ingress port.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  NUM_PORTS  per-ingress packet valid.
- in_ready  out  NUM_PORTS  per-ingress FIFO not full.
- in_source  in  NUM_PORTS x NUM_PORTS  source mask, passed through untouched.
- in_target  in  NUM_PORTS x NUM_PORTS  destination mask; multiple bits = multicast.
- in_data  in  NUM_PORTS x DATA_W  payload.
- out_valid  out  NUM_PORTS  per-egress packet valid, one-cycle pulse per packet.
- out_source  out  NUM_PORTS x NUM_PORTS  source field of the delivered packet.
- out_target  out  NUM_PORTS x NUM_PORTS  original target mask as received.
- out_data  out  NUM_PORTS x DATA_W  payload.
- drop_count  out  16  saturating count of dropped packets.

Behaviour:
- Reset (async assert, synchronous-release use):
  - All FIFOs empty; served masks and RR pointers set to 0; drop_count = 0.
  - out_valid, out_source, out_target, out_data = 0; in_ready = all 1s after reset.
  - Reset mid-operation discards all queued and partially delivered packets without emitting them.
- Ingress:
  - Push when in_valid[i] && in_ready[i] at a rising edge.
  - in_ready[i] = FIFO count < FIFO_DEPTH, driven from registered count only; no combinational path from in_valid.
  - When full, in_ready is 0 even if a pop happens in the same cycle.
  - in_valid while in_ready is low: the packet is ignored, not counted as a drop.
- Effective mask at push: eff = in_target, with bit i cleared if ALLOW_HAIRPIN = 0.
  - eff == 0: packet is not written to the FIFO; drop_count increments (saturates at 16'hFFFF).
  - in_ready is unaffected by a drop.
  - The FIFO stores {source, original target, eff, data}.
- Request:
  - Non-empty ingress i requests egress o when rem_i[o] = 1, where rem_i = head.eff & ~served_i.
- Arbitration, per egress o:
  - Round-robin over requesting inputs, starting at ptr_o.
  - On grant to input g: ptr_o <= (g+1) mod NUM_PORTS. No grant: ptr_o holds.
  - One grant per egress per cycle.
  - One input may win several egresses in the same cycle (parallel multicast).
- Output register, at the edge after a grant:
  - out_valid[o] = 1; out_source/out_target/out_data take the head fields of the granted input.
  - When no grant, all out_* for that egress = 0.
- Multicast completion:
  - served_i |= grants for input i.
  - When rem_i & ~grants_i == 0: pop the head and clear served_i in the same edge.
  - The next head may be requested in the following cycle.
- Latency: packet pushed at edge k with an empty FIFO and no contention → out_valid high in the cycle after edge k+1. Minimum 1 cycle from the push edge.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Ordering: each ingress preserves per-egress order; there is no ordering guarantee across ingress ports.

Decomposition:
- Package switch_nport_pkg:
  - Default parameter constants.
  - Function rr_pick(req, ptr) returning a one-hot grant.
  - Function popcount for masks.
- Sub-module switch_port_fifo: parametrised synchronous FIFO with data width, depth, count, full, empty, push, pop, head. Instantiated NUM_PORTS times.
- Arbiters, served masks and output registers stay in the top level.

Test Plan (defaults NUM_PORTS=4, DATA_W=8, FIFO_DEPTH=4, ALLOW_HAIRPIN=0):
- Unicast: port0 sends src=0001 tgt=0010 data=51 at edge k → only out_valid[1] high in the cycle after edge k+1, with out_data=51, out_source=0001, out_target=0010; drop_count=0.
- Contention: port0 (data C0) and port1 (data C1), both tgt=0100, in the same cycle after reset → egress2 emits C0, then C1 on the next cycle; ptr_2 ends at 2. Repeat the same pair → C0 then C1 again.
- Broadcast, hairpin off: port1 sends tgt=1111 data=B2 → egresses 0, 2, 3 all valid in the same cycle with out_target=1111; egress1 silent; port1 FIFO empty after 1 cycle.
- Multicast serialisation under contention:
  - port0 sends tgt=1110 data=A1.
  - port3 sends tgt=0100 data=E3 in the same cycle.
  - egresses 1 and 3 take A1 immediately.
  - egress2 emits A1 then E3 on consecutive cycles.
  - port0 head pops only after its egress2 delivery.
- Backpressure and drop:
  - Hold egress contention so that port0 pushes 5 packets → in_ready[0] drops after 4 accepted.
  - The 5th packet is ignored, not counted as a drop.
  - Separately, port2 sends tgt=0100 (self only) → drop_count=1, no output.
- Reset mid-flight: 3 packets queued at port0, assert rst_n=0 for 2 cycles → all out_valid=0 immediately (async), FIFO empty, no queued packet emitted after release.
